// File: rtl/shift_pkg.sv
// Shared types and helpers for the parallel-in / serial-out shift register.
// cnt_w sizes any counter that must hold the values 0..Length inclusive.
package shift_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } p2s_state_e;

  function automatic int unsigned cnt_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/shift_reg_par_load_serial_out.sv
// Parallel-in / serial-out shift register.
// Captures a Length-word vector in one handshake and streams it out, index Length-1 first.
module shift_reg_par_load_serial_out
  import shift_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned Length = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N-1:0]                rst_val_i,
  input  logic                        flush_i,
  input  logic                        load_valid_i,
  output logic                        load_ready_o,
  input  logic [N-1:0]                load_data_i [Length-1:0],
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [N-1:0]                data_o,
  output logic                        last_o,
  output logic [cnt_w(Length)-1:0]    count_o,
  output logic                        busy_o
);

  localparam int unsigned CW = cnt_w(Length);

  p2s_state_e    state;
  logic [CW-1:0] count;
  logic          beat;
  logic          load_fire;

  always_comb begin
    valid_o      = (state == STREAM);
    busy_o       = (state == STREAM);
    beat         = valid_o & ready_i;
    last_o       = valid_o & (count == CW'(1));
    // Flush has priority, so no load may be accepted in a flush cycle.
    load_ready_o = ~flush_i & ((state == IDLE) | (beat & last_o));
    load_fire    = load_valid_i & load_ready_o;
    count_o      = count;
  end

  // Each stage owns its register; stage 0 refills with rst_val_i on every beat.
  for (genvar i = 0; i < Length; i++) begin : g_stage
    logic [N-1:0] q;
    logic [N-1:0] shift_in;

    if (i == 0) begin : g_head
      always_comb shift_in = rst_val_i;
    end else begin : g_body
      always_comb shift_in = g_stage[i-1].q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        q <= rst_val_i;
      end else if (flush_i) begin
        q <= rst_val_i;
      end else if (load_fire) begin
        q <= load_data_i[i];
      end else if (beat) begin
        q <= shift_in;
      end
    end
  end

  assign data_o = g_stage[Length-1].q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      count <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      count <= '0;
    end else if (load_fire) begin
      state <= STREAM;
      count <= CW'(Length);
    end else if (beat) begin
      count <= count - CW'(1);
      if (last_o) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_par_load_serial_out.sv
// Scoreboard bench: stimulus pushes the words each accepted vector must produce,
// a negedge monitor compares them against every presented output word.
module tb_shift_reg_par_load_serial_out;

  localparam int unsigned N = 8;
  localparam int unsigned L = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] rst_val_i;
  logic         flush_i;
  logic         load_valid_i;
  logic         load_ready_o;
  logic [N-1:0] load_data_i [L-1:0];
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] data_o;
  logic         last_o;
  logic [1:0]   count_o;
  logic         busy_o;

  shift_reg_par_load_serial_out #(.N(N), .Length(L)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rst_val_i    (rst_val_i),
    .flush_i      (flush_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_data_i  (load_data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .count_o      (count_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] d;
    logic         last;
    int unsigned  cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference behaviour: a vector is emitted highest index first, one word per beat,
  // and the count shown with each word is the number of words still to go.
  function automatic void push_vector(input logic [N-1:0] v2, input logic [N-1:0] v1,
                                      input logic [N-1:0] v0);
    logic [N-1:0] w [3];
    w[0] = v2; w[1] = v1; w[2] = v0;
    for (int unsigned j = 0; j < L; j++) begin
      exp_t e;
      e.d    = w[j];
      e.last = (j == L - 1);
      e.cnt  = L - j;
      sb.push_back(e);
    end
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", {31'd0, valid_o}, 32'd0);
        end else begin
          chk("data", {24'd0, data_o}, {24'd0, sb[0].d});
          chk("last", {31'd0, last_o}, {31'd0, sb[0].last});
          chk("count", {30'd0, count_o}, sb[0].cnt);
          if (ready_i) void'(sb.pop_front());
        end
      end else begin
        chk("idle_last", {31'd0, last_o}, 32'd0);
        if (sb.size() == 0) chk("idle_data", {24'd0, data_o}, {24'd0, rst_val_i});
      end
    end
  end

  // One cycle of stimulus, starting and ending just after a rising edge.
  task automatic drive(input bit lv, input logic [N-1:0] v2, input logic [N-1:0] v1,
                       input logic [N-1:0] v0, input bit rdy, input bit fl, output bit fired);
    bit exp_rdy;
    load_valid_i   = lv;
    load_data_i[2] = v2;
    load_data_i[1] = v1;
    load_data_i[0] = v0;
    ready_i        = rdy;
    flush_i        = fl;
    if (fl) sb.delete();
    #1;
    exp_rdy = !fl && (sb.size() == 0 || (sb.size() == 1 && rdy));
    chk("load_ready", {31'd0, load_ready_o}, {31'd0, exp_rdy});
    fired = lv && exp_rdy;
    if (fired) push_vector(v2, v1, v0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycle(input bit rdy);
    bit f;
    drive(1'b0, '0, '0, '0, rdy, 1'b0, f);
  endtask

  task automatic drain(input int unsigned maxc);
    int unsigned n = 0;
    while (sb.size() != 0 && n < maxc) begin
      idle_cycle(1'b1);
      n++;
    end
    chk("drain_done", sb.size(), 32'd0);
    idle_cycle(1'b1);
    chk("drained_valid", {31'd0, valid_o}, 32'd0);
    chk("drained_busy", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic do_reset(input logic [N-1:0] rv);
    rst_val_i = rv;
    rst_i     = 1'b1;
    sb.delete();
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready_o}, 32'd1);
    chk("rst_data", {24'd0, data_o}, {24'd0, rv});
    chk("rst_count", {30'd0, count_o}, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit f;
    bit acc2;
    logic [N-1:0] st [3];
    logic [7:0] seq [3];

    rst_i        = 1'b1;
    rst_val_i    = 8'hAA;
    flush_i      = 1'b0;
    load_valid_i = 1'b0;
    ready_i      = 1'b0;
    for (int i = 0; i < 3; i++) load_data_i[i] = '0;
    @(posedge clk_i);
    #1;
    do_reset(8'hAA);

    // Basic stream with ready_i held high.
    drive(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, f);
    chk("basic_fired", {31'd0, f}, 32'd1);
    chk("basic_valid_latency", {31'd0, valid_o}, 32'd1);
    chk("basic_busy", {31'd0, busy_o}, 32'd1);
    drain(10);

    // Stall for four cycles on the second word.
    drive(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, f);
    idle_cycle(1'b1);
    for (int i = 0; i < 4; i++) begin
      idle_cycle(1'b0);
      chk("stall_data", {24'd0, data_o}, 32'h22);
      chk("stall_count", {30'd0, count_o}, 32'd2);
    end
    drain(10);

    // Back-to-back: second vector held until accepted on the final beat.
    drive(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, f);
    acc2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("b2b_valid", {31'd0, valid_o}, 32'd1);
      drive(!acc2, 8'h44, 8'h55, 8'h66, 1'b1, 1'b0, f);
      if (f) acc2 = 1'b1;
    end
    chk("b2b_accepted", {31'd0, acc2}, 32'd1);
    drain(10);

    // Flush after the first beat, then a fresh vector.
    drive(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, f);
    idle_cycle(1'b1);
    drive(1'b1, 8'hEE, 8'hEE, 8'hEE, 1'b1, 1'b1, f);
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_count", {30'd0, count_o}, 32'd0);
    drive(1'b1, 8'h77, 8'h88, 8'h99, 1'b1, 1'b0, f);
    chk("flush_reload", {31'd0, f}, 32'd1);
    drain(10);

    // Round trip through a serial-in store holding 01,02,03.
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03;
    for (int i = 0; i < 3; i++) st[i] = rst_val_i;
    for (int k = 0; k < 3; k++) begin
      st[2] = st[1];
      st[1] = st[0];
      st[0] = seq[k];
    end
    drive(1'b1, st[2], st[1], st[0], 1'b1, 1'b0, f);
    chk("rt_first", {24'd0, data_o}, {24'd0, seq[0]});
    drain(10);

    // Async reset in the middle of a stream.
    drive(1'b1, 8'h5A, 8'h6B, 8'h7C, 1'b1, 1'b0, f);
    idle_cycle(1'b0);
    #2;
    do_reset(8'h3C);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, f);
    end
    drain(20);

    do_reset(8'($urandom));
    drive(1'b1, 8'hC1, 8'hC2, 8'hC3, 1'b1, 1'b0, f);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
